// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: multi-digit packed-BCD modulo counter with up/down stepping,
// enable-gated prescaler, validated synchronous load and registered one-cycle
// terminal-count / load-error pulses. Digit 0 sits in bits [3:0].
module bcd_mod_counter #(
    parameter int NUM_DIGITS = 2,
    parameter int MODULUS    = 60,
    parameter int PRESCALE   = 1
) (
    input  logic                    clki,
    input  logic                    rs,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    tc,
    output logic                    load_err
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);
    localparam logic [31:0]   MOD_U    = 32'(MODULUS);

    // Binary -> packed BCD, used at elaboration for the down-wrap target.
    function automatic logic [W-1:0] to_bcd(input int v);
        int            r;
        logic [W-1:0]  b;
        r = v;
        b = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            b[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return b;
    endfunction

    localparam logic [W-1:0] TOP_BCD = to_bcd(MODULUS - 1);

    logic [PW-1:0] psc;
    logic          tick;
    logic          load_ok;
    logic [31:0]   bin;
    logic [W-1:0]  inc_val;
    logic [W-1:0]  dec_val;
    logic [W-1:0]  step_val;
    logic          carry;
    logic          borrow;
    logic [3:0]    dig;
    logic          at_wrap;

    // Tick on the last prescaler phase; with PRESCALE=1 psc stays 0 so tick = en.
    assign tick = en && (psc == PSC_LAST);

    // Load validation: every digit must be decimal and the value below MODULUS.
    always_comb begin
        load_ok = 1'b1;
        bin     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
            bin = bin * 32'd10 + {28'd0, load_val[4*i +: 4]};
        end
        if (bin >= MOD_U) load_ok = 1'b0;
    end

    // Ripple BCD increment and decrement of the current count.
    always_comb begin
        inc_val = count;
        dec_val = count;
        carry   = 1'b1;
        borrow  = 1'b1;
        dig     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = count[4*i +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = dig + 4'd1;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (dig == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = dig - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    // Modulo wrap overrides the plain BCD step at either end of the range.
    always_comb begin
        at_wrap  = up_dn ? (count == TOP_BCD) : (count == '0);
        step_val = up_dn ? inc_val : dec_val;
        if (at_wrap) step_val = up_dn ? '0 : TOP_BCD;
    end

    // State update: load beats tick; a rejected load freezes psc and count.
    always_ff @(posedge clki or negedge rs) begin
        if (!rs) begin
            count    <= '0;
            psc      <= '0;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tc       <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    count <= load_val;
                    psc   <= '0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                psc <= tick ? '0 : psc + PW'(1);
                if (tick) begin
                    count <= step_val;
                    tc    <= at_wrap;
                end
            end
        end
    end

endmodule
